// File: rtl/prio_enc_seg_scan.sv
// Debounced active-low priority encoder that shows the winning index in decimal
// on a scanned two-digit 7-segment display, with live and latch-until-clear modes.
module prio_enc_seg_scan #(
    parameter int N_IN     = 16,
    parameter int IDX_W    = 4,
    parameter int DEB_CYC  = 4,
    parameter int SCAN_DIV = 1000,
    parameter int MAX_SHOW = 9
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             EI,
    input  logic [N_IN-1:0]  DataIn,
    input  logic             HOLD,
    input  logic             CLR,
    output logic [IDX_W-1:0] Code,
    output logic             GS,
    output logic             EO,
    output logic             Valid,
    output logic [7:0]       Seg,
    output logic [1:0]       Dig
);
    localparam int DEB_W  = $clog2(DEB_CYC + 1);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYC - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

    generate
        if (IDX_W != $clog2(N_IN)) begin : g_bad_idx_w
            $error("IDX_W must equal clog2(N_IN)");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_HELD} state_t;

    logic [N_IN-1:0]   r_sync1, r_sync2, r_prev, r_stable;
    logic [DEB_W-1:0]  r_deb_cnt, w_deb_nxt;
    logic [IDX_W-1:0]  r_code, w_idx;
    logic              r_eo, r_valid, w_any, w_req, w_load, w_gs, w_over, r_dsel;
    state_t            r_state, w_state_nxt;
    logic [SCAN_W-1:0] r_scan;
    logic [7:0]        r_seg;
    logic [1:0]        r_dig;
    logic [6:0]        w_code_ext;
    logic [3:0]        w_ones, w_tens;

    // The stable vector is refreshed on the same edge the counter reaches its
    // terminal value, which gives 2+DEB_CYC+1 cycles from pin to Code.
    always_comb begin
        w_deb_nxt = '0;
        if (r_sync2 == r_prev)
            w_deb_nxt = (r_deb_cnt == DEB_MAX) ? DEB_MAX : r_deb_cnt + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_sync1   <= '1;
            r_sync2   <= '1;
            r_prev    <= '1;
            r_stable  <= '1;
            r_deb_cnt <= '0;
            r_eo      <= 1'b1;
        end else begin
            r_sync1   <= DataIn;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_deb_cnt <= w_deb_nxt;
            if (w_deb_nxt == DEB_MAX)
                r_stable <= r_sync2;
            r_eo      <= EI | w_any;
        end
    end

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N_IN; i++)
            if (!r_stable[i]) w_idx = IDX_W'(i);
    end
    assign w_any = ~&r_stable;
    assign w_req = ~EI & w_any;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: if (w_req) begin
                w_load      = 1'b1;
                w_state_nxt = HOLD ? S_HELD : S_SHOW;
            end
            S_SHOW: begin
                if (HOLD)               w_state_nxt = S_HELD;
                else if (!w_req)        w_state_nxt = S_IDLE;
                else if (w_idx != r_code) w_load    = 1'b1;
            end
            S_HELD: begin
                if (CLR)                w_state_nxt = S_IDLE;
                else if (!HOLD)         w_state_nxt = w_req ? S_SHOW : S_IDLE;
            end
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_gs = (r_state == S_IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_code  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_load;
            if (w_load) r_code <= w_idx;
        end
    end

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 8'h3F;  4'd1: seg7 = 8'h06;
            4'd2: seg7 = 8'h5B;  4'd3: seg7 = 8'h4F;
            4'd4: seg7 = 8'h66;  4'd5: seg7 = 8'h6D;
            4'd6: seg7 = 8'h7D;  4'd7: seg7 = 8'h07;
            4'd8: seg7 = 8'h7F;  4'd9: seg7 = 8'h6F;
            default: seg7 = 8'h00;
        endcase
    endfunction

    assign w_code_ext = 7'(r_code);
    assign w_ones     = 4'(w_code_ext % 7'd10);
    assign w_tens     = 4'(w_code_ext / 7'd10);
    assign w_over     = 32'(r_code) > 32'(MAX_SHOW);

    // Seg and Dig share one register so the digit switch and pattern change land together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_scan <= '0;
            r_dsel <= 1'b0;
            r_seg  <= 8'h00;
            r_dig  <= 2'b11;
        end else begin
            if (r_scan == SCAN_MAX) begin
                r_scan <= '0;
                r_dsel <= ~r_dsel;
            end else begin
                r_scan <= r_scan + 1'b1;
            end
            if (r_state == S_IDLE || w_over) begin
                r_seg <= 8'h00;
                r_dig <= 2'b11;
            end else if (!r_dsel) begin
                r_seg <= seg7(w_ones);
                r_dig <= 2'b10;
            end else begin
                r_seg <= (w_tens == 4'd0) ? 8'h00 : seg7(w_tens);
                r_dig <= 2'b01;
            end
        end
    end

    assign Code  = r_code;
    assign GS    = w_gs;
    assign EO    = r_eo;
    assign Valid = r_valid;
    assign Seg   = r_seg;
    assign Dig   = r_dig;
endmodule

// File: tb/tb_prio_enc_seg_scan.sv
// Directed bench: two instances (MAX_SHOW=15 and MAX_SHOW=9) share stimulus;
// expected values are hand-derived.
module tb_prio_enc_seg_scan;
  localparam int SD = 8;

  logic CLK, nRST, EI, HOLD, CLR;
  logic [15:0] DataIn;
  logic [3:0] Code, Code9;
  logic GS, EO, Valid, GS9, EO9, Valid9;
  logic [7:0] Seg, Seg9;
  logic [1:0] Dig, Dig9;

  int n_chk = 0;
  int n_err = 0;

  prio_enc_seg_scan #(.N_IN(16), .IDX_W(4), .DEB_CYC(4), .SCAN_DIV(SD), .MAX_SHOW(15)) u_dut (
    .CLK(CLK), .nRST(nRST), .EI(EI), .DataIn(DataIn), .HOLD(HOLD), .CLR(CLR),
    .Code(Code), .GS(GS), .EO(EO), .Valid(Valid), .Seg(Seg), .Dig(Dig));

  prio_enc_seg_scan #(.N_IN(16), .IDX_W(4), .DEB_CYC(4), .SCAN_DIV(SD), .MAX_SHOW(9)) u_dut9 (
    .CLK(CLK), .nRST(nRST), .EI(EI), .DataIn(DataIn), .HOLD(HOLD), .CLR(CLR),
    .Code(Code9), .GS(GS9), .EO(EO9), .Valid(Valid9), .Seg(Seg9), .Dig(Dig9));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic watch(input int n, output int cnt, output int first);
    cnt = 0; first = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge CLK);
      if (Valid) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic wait_dig(input logic [1:0] d, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 4*SD && !ok; k++) begin
      @(negedge CLK);
      if (Dig == d) ok = 1'b1;
    end
  endtask

  initial begin
    int vc, vf, c1, n;
    logic ok, flag;
    nRST = 1'b0; EI = 1'b0; DataIn = '1; HOLD = 1'b0; CLR = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_code", Code, 0);
    check("rst_gs", GS, 1);
    check("rst_eo", EO, 1);
    check("rst_valid", Valid, 0);
    check("rst_seg", Seg, 0);
    check("rst_dig", Dig, 2'b11);
    nRST = 1'b1;
    repeat (4) @(negedge CLK);
    check("idle_eo", EO, 0);

    // bit3 alone
    DataIn = 16'hFFF7;
    watch(12, vc, vf);
    check("b3_valid_cnt", vc, 1);
    check("b3_latency", vf, 7);
    check("b3_code", Code, 3);
    check("b3_gs", GS, 0);
    check("b3_eo", EO, 1);
    wait_dig(2'b10, ok);
    check("b3_ones_found", ok, 1);
    check("b3_ones_seg", Seg, 8'h4F);
    wait_dig(2'b01, ok);
    check("b3_tens_found", ok, 1);
    check("b3_tens_blank", Seg, 0);

    // bits 3 and 12: priority and two-digit display
    DataIn = 16'hEFF7;
    watch(12, vc, vf);
    check("b12_valid_cnt", vc, 1);
    check("b12_code", Code, 12);
    wait_dig(2'b10, ok);
    wait_dig(2'b01, ok);
    check("b12_tens_found", ok, 1);
    check("b12_tens_seg", Seg, 8'h06);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (Dig == 2'b01 && n < 4*SD);
    check("slot_len", n, SD);
    check("b12_ones_dig", Dig, 2'b10);
    check("b12_ones_seg", Seg, 8'h5B);

    // release, then short glitch on bit5
    DataIn = '1;
    watch(12, vc, vf);
    check("rel_valid_cnt", vc, 0);
    check("rel_gs", GS, 1);
    check("rel_eo", EO, 0);
    check("rel_seg", Seg, 0);
    check("rel_dig", Dig, 2'b11);
    DataIn = 16'hFFDF;
    vc = 0; flag = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLK);
      if (k == 3) DataIn = '1;
      if (Valid) vc++;
      if (EO) flag = 1'b1;
    end
    check("glitch_valid", vc, 0);
    check("glitch_eo", flag, 0);
    check("glitch_code", Code, 12);

    // hold mode: bit7 then bit9
    HOLD = 1'b1;
    DataIn = 16'hFF7F;
    watch(12, c1, vf);
    check("hold7_code", Code, 7);
    check("hold7_gs", GS, 0);
    DataIn = 16'hFD7F;
    watch(12, vc, vf);
    check("hold_valid_total", c1 + vc, 1);
    check("hold9_code_frozen", Code, 7);
    check("hold9_gs", GS, 0);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    check("clr_gs", GS, 1);
    @(negedge CLK);
    check("clr_reload_valid", Valid, 1);
    check("clr_reload_code", Code, 9);
    check("clr_blank_seg", Seg, 0);
    check("clr_blank_dig", Dig, 2'b11);
    check("clr_reload_gs", GS, 0);
    HOLD = 1'b0;
    DataIn = '1;
    repeat (12) @(negedge CLK);

    // code above MAX_SHOW on the MAX_SHOW=9 instance
    DataIn = 16'hF7FF;
    watch(12, vc, vf);
    check("b11_code9", Code9, 11);
    check("b11_gs9", GS9, 0);
    check("b11_code", Code, 11);
    flag = 1'b0;
    for (int k = 0; k < 2*SD; k++) begin
      @(negedge CLK);
      if (Seg9 != 8'h00 || Dig9 != 2'b11) flag = 1'b1;
    end
    check("b11_blank9", flag, 0);
    EI = 1'b1;
    repeat (2) @(negedge CLK);
    check("ei_eo9", EO9, 1);
    check("ei_gs9", GS9, 1);
    check("ei_gs", GS, 1);
    EI = 1'b0;
    DataIn = '1;
    repeat (12) @(negedge CLK);

    // async reset while HELD
    HOLD = 1'b1;
    DataIn = 16'hFFF7;
    watch(12, vc, vf);
    check("held_gs", GS, 0);
    check("held_code", Code, 3);
    #2 nRST = 1'b0;
    #1;
    check("arst_code", Code, 0);
    check("arst_gs", GS, 1);
    check("arst_eo", EO, 1);
    check("arst_valid", Valid, 0);
    check("arst_seg", Seg, 0);
    check("arst_dig", Dig, 2'b11);
    check("arst_code9", Code9, 0);
    HOLD = 1'b0;
    DataIn = '1;
    @(negedge CLK);
    nRST = 1'b1;
    watch(12, vc, vf);
    check("post_rst_valid", vc, 0);
    check("post_rst_gs", GS, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/prio_enc_seg_scan.md
Name: prio_enc_seg_scan

Overview:
Registered, parametrised successor to the cascaded 74HC148 / 74HC4511 display path. N_IN active-low request lines pass through a synchroniser and a debouncer, then a priority encoder selects the highest active index. The index is shown in decimal on a time-multiplexed two-digit 7-segment display. The block supports a live mode and a hold (latch-until-clear) mode, and blanks the display when the code exceeds a limit.

Parameters:
N_IN, 16, number of request inputs (2..64)
IDX_W, 4, code width; must equal clog2(N_IN), checked at elaboration
DEB_CYC, 4, consecutive identical samples required to accept an input vector (>=1)
SCAN_DIV, 1000, CLK cycles per digit slot (>=2)
MAX_SHOW, 9, largest code displayed; codes above this blank both digits

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  reset, asynchronous assert, active-low
EI  in  1  encoder enable, active-low
DataIn  in  N_IN  request lines, active-low; bit N_IN-1 has highest priority
HOLD  in  1  1 = hold mode, 0 = live mode
CLR  in  1  synchronous clear of held code, active-high
Code  out  IDX_W  registered encoded index
GS  out  1  group select, active-low: a displayed code is valid
EO  out  1  enable out, active-low: EI low and no request active
Valid  out  1  one-cycle pulse when Code loads a new value
Seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-high; dp is always 0
Dig  out  2  digit enables, active-low; Dig[0] = ones, Dig[1] = tens

Behaviour:
- Reset (nRST=0, asynchronous): all registers clear. Code=0, GS=1, EO=1, Valid=0, Seg=0, Dig=2'b11, FSM=IDLE, scan counter=0, debounce counter=0, sync/stable vectors = all-ones (inactive).
- Synchroniser: 2-flop on DataIn.
- Debounce: sync output is compared with the previous sample. A difference resets the counter to 0. An equal sample increments the counter, saturating at DEB_CYC-1. On the cycle the counter equals DEB_CYC-1, the sample is copied into the stable vector. Minimum latency from DataIn pin change to Code/GS update is 2+DEB_CYC+1 cycles.
- Encoder (combinational on the stable vector): req = EI low AND any stable bit low. idx = highest index whose bit is low.
- EO is registered: EO = ~(EI==0 && no stable bit low). EI high gives EO=1 and req=0.
- FSM:
  - IDLE: Code holds its last value; GS=1. If req: load Code=idx, pulse Valid, go to SHOW.
  - SHOW (live, HOLD=0): if req and idx!=Code, load and pulse Valid. If !req, go to IDLE. If HOLD=1, go to HELD.
  - HELD: Code frozen; GS=0; requests ignored. CLR=1 goes to IDLE next cycle. HOLD=0 with no CLR goes to SHOW if req, else IDLE.
  - From IDLE with HOLD=1 and req: load, pulse Valid, go directly to HELD.
  - CLR in IDLE or SHOW has no effect. CLR and a new req in the same cycle while HELD: CLR wins; the request is picked up from IDLE on the next cycle.
- GS = 0 in SHOW and HELD, 1 in IDLE.
- Display:
  - Scan counter runs 0..SCAN_DIV-1 and wraps; the active digit toggles on wrap, starting with ones after reset.
  - Ones = Code mod 10; tens = Code / 10.
  - Tens digit is blanked when it is 0 (leading-zero suppression).
  - In IDLE, or when Code > MAX_SHOW, both digits are blanked: Seg=0, Dig=2'b11.
  - Seg and Dig are registered together, so there is no glitch between digit switch and segment update.
  - Patterns, a = bit0: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Reset mid-debounce or mid-hold discards all state; there are no pending pulses after release.

Test Plan:
- Reset, then N_IN=16, MAX_SHOW=15, EI=0, DataIn=16'hFFF7 (bit3) stable: Code=3 with one Valid pulse 2+DEB_CYC+1 cycles after the edge, GS=0, EO=1. Dig[0] slot: Seg=4F; Dig[1] slot: blank.
- DataIn with bits 3 and 12 both low: Code=12. Tens slot Seg=06, ones slot Seg=5B, digits alternating every SCAN_DIV cycles.
- Bit5 glitch low for DEB_CYC-1 cycles: no Code change, no Valid, EO stays 0.
- HOLD=1, press bit7 then bit9: Code stays 7, one Valid only. CLR pulse returns to IDLE (GS=1, display blank); the still-pressed bit9 then loads Code=9.
- MAX_SHOW=9, press bit11: Code=11, GS=0, Seg=0, Dig=2'b11. EI=1: EO=1, GS=1, FSM returns to IDLE.
- Assert nRST during HELD: outputs go to reset values immediately, without waiting for a CLK edge.
